// File: rtl/aes_spi_sequencer_pkg.sv
// Shared types and field-width helpers for the AES-over-SPI job sequencer.
package aes_spi_pkg;

  localparam int unsigned NK_DEF = 8;
  localparam int unsigned NB_DEF = 4;
  localparam int unsigned NR_DEF = 14;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    RECV,
    RESP,
    GAP
  } state_t;

  function automatic int unsigned key_w(input int unsigned nk);
    return 32 * nk;
  endfunction

  function automatic int unsigned blk_w(input int unsigned nb);
    return 32 * nb;
  endfunction

  // Frame on the wire: {mode, key, message}
  function automatic int unsigned frame_w(input int unsigned nk, input int unsigned nb);
    return 1 + key_w(nk) + blk_w(nb);
  endfunction

endpackage

// File: rtl/aes_spi_sequencer_if.sv
// Host-side job request / result response bundle for aes_spi_sequencer.
interface aes_spi_sequencer_if #(
  parameter int unsigned nk = 8,
  parameter int unsigned nb = 4
);

  logic              req_valid;
  logic              req_ready;
  logic              req_mode;
  logic [32*nk-1:0]  req_key;
  logic [32*nb-1:0]  req_msg;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [32*nb-1:0]  rsp_data;

  modport master (
    output req_valid, req_mode, req_key, req_msg, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_mode, req_key, req_msg, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/aes_spi_sequencer_bit_timer.sv
// SPI bit-period phase counter: end-of-period strobe and high-half indicator.
module spi_bit_timer #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic period_end,
  output logic sclk_hi
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] phase;

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      phase <= '0;
    end else if (phase == PW'(CLK_DIV - 1)) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign period_end = en && (phase == PW'(CLK_DIV - 1));
  assign sclk_hi    = en && (phase >= PW'(CLK_DIV / 2));

endmodule

// File: rtl/aes_spi_sequencer.sv
// Single-job AES-over-SPI controller: ships {mode,key,msg} to the subnode,
// waits out the compute window, shifts the result back and hands it to the host.
module aes_spi_sequencer
  import aes_spi_pkg::*;
#(
  parameter int unsigned nk        = 8,
  parameter int unsigned nb        = 4,
  parameter int unsigned nr        = 14,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CALC_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_spi_sequencer_if.slave     bus,
  output logic                   busy,
  output logic                   spi_cs_n,
  output logic                   spi_sclk,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);

  localparam int unsigned KEY_W = key_w(nk);
  localparam int unsigned BLK_W = blk_w(nb);
  localparam int unsigned FRAME = frame_w(nk, nb);
  localparam int unsigned CW    = $clog2(FRAME + 1);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0 || CALC_WAIT < 1 || CALC_WAIT > FRAME ||
      !(nk == 4 || nk == 6 || nk == 8) || nr != nk + 6) begin : g_bad_params
    $error("aes_spi_sequencer: unsupported parameter set");
  end

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    bit_cnt;
  logic [FRAME-1:0] frame_sr;
  logic [BLK_W-1:0] rsp_sr;

  logic timer_en;
  logic timer_clr;
  logic period_end;
  logic sclk_hi;
  logic accept;

  assign timer_en  = (state == SEND) || (state == WAIT) || (state == RECV) || (state == GAP);
  assign timer_clr = (state_next != state);
  assign accept    = (state == IDLE) && bus.req_valid;

  spi_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .en         (timer_en),
    .clr        (timer_clr),
    .period_end (period_end),
    .sclk_hi    (sclk_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    spi_cs_n      = 1'b1;
    spi_sclk      = 1'b0;
    spi_mosi      = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (bus.req_valid) state_next = SEND;
      end
      SEND: begin
        spi_cs_n = 1'b0;
        spi_sclk = sclk_hi;
        spi_mosi = frame_sr[FRAME-1];
        if (period_end && bit_cnt == CW'(FRAME - 1)) state_next = WAIT;
      end
      WAIT: begin
        spi_cs_n = 1'b0;
        if (period_end && bit_cnt == CW'(CALC_WAIT - 1)) state_next = RECV;
      end
      RECV: begin
        spi_cs_n = 1'b0;
        spi_sclk = sclk_hi;
        if (period_end && bit_cnt == CW'(BLK_W - 1)) state_next = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_next = GAP;
      end
      GAP: begin
        if (period_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // bit_cnt counts completed bit periods within the current state only
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      frame_sr <= '0;
      rsp_sr   <= '0;
    end else begin
      if (state_next != state) begin
        bit_cnt <= '0;
      end else if (period_end) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (accept) begin
        frame_sr <= {bus.req_mode, bus.req_key, bus.req_msg};
      end else if (state == SEND && period_end) begin
        frame_sr <= {frame_sr[FRAME-2:0], 1'b0};
      end

      if (accept) begin
        rsp_sr <= '0;
      end else if (state == RECV && period_end) begin
        rsp_sr <= {rsp_sr[BLK_W-2:0], spi_miso};
      end
    end
  end

  assign bus.rsp_data = rsp_sr;

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Randomised self-checking bench for aes_spi_sequencer with a behavioural SPI subnode.
module tb_aes_spi_sequencer;
  import aes_spi_pkg::*;

  localparam int unsigned NK        = 8;
  localparam int unsigned NB        = 4;
  localparam int unsigned NR        = 14;
  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned CALC_WAIT = 4;
  localparam int unsigned KEY_W     = 32 * NK;
  localparam int unsigned BLK_W     = 32 * NB;
  localparam int unsigned FRAME_W   = 1 + KEY_W + BLK_W;
  localparam int unsigned LATENCY   = 1 + (FRAME_W + CALC_WAIT + BLK_W) * CLK_DIV;

  typedef logic [FRAME_W-1:0] val_t;

  logic clk;
  logic rst;
  logic busy;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso = 1'b0;

  aes_spi_sequencer_if #(.nk(NK), .nb(NB)) bus ();

  aes_spi_sequencer #(
    .nk        (NK),
    .nb        (NB),
    .nr        (NR),
    .CLK_DIV   (CLK_DIV),
    .CALC_WAIT (CALC_WAIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input val_t act, input val_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Subnode model: first FRAME_W rising sclk edges capture mosi, next BLK_W drive miso MSB first.
  logic [FRAME_W-1:0] slv_frame = '0;
  logic [BLK_W-1:0]   slv_ret   = '0;
  int unsigned slv_tx = 0, slv_rx = 0, slv_tx_last = 0, slv_rx_last = 0;

  always @(posedge spi_sclk or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      slv_tx_last = slv_tx;
      slv_rx_last = slv_rx;
      slv_tx      = 0;
      slv_rx      = 0;
      spi_miso    = 1'b0;
    end else if (slv_tx < FRAME_W) begin
      slv_frame = {slv_frame[FRAME_W-2:0], spi_mosi};
      slv_tx++;
    end else if (slv_rx < BLK_W) begin
      spi_miso = slv_ret[BLK_W-1-slv_rx];
      slv_rx++;
    end
  end

  int unsigned idle_viol = 0;
  always @(negedge clk) begin
    if (!rst && spi_cs_n && (spi_sclk || spi_mosi)) idle_viol++;
  end

  function automatic logic [KEY_W-1:0] rand_key();
    logic [KEY_W-1:0] r = '0;
    for (int unsigned i = 0; i < NK; i++) r = {r[KEY_W-33:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] rand_blk();
    logic [BLK_W-1:0] r = '0;
    for (int unsigned i = 0; i < NB; i++) r = {r[BLK_W-33:0], 32'($urandom())};
    return r;
  endfunction

  bit prev_hold = 1'b0;

  task automatic run_job(input logic mode, input logic [KEY_W-1:0] key,
                         input logic [BLK_W-1:0] msg, input logic [BLK_W-1:0] ret,
                         input int unsigned bp, input bit hold);
    int unsigned k;
    bit ok;
    logic [BLK_W-1:0] held;
    bus.req_mode  = mode;
    bus.req_key   = key;
    bus.req_msg   = msg;
    bus.req_valid = 1'b1;
    slv_ret       = ret;
    k = 0;
    while (!bus.req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("req_ready_idle", val_t'(bus.req_ready), val_t'(1));
    if (prev_hold) check_eq("b2b_accept_wait", val_t'(k), val_t'(0));
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
    check_eq("cs_n_after_accept", val_t'(spi_cs_n), val_t'(0));
    check_eq("first_mosi_mode", val_t'(spi_mosi), val_t'(mode));
    check_eq("busy_after_accept", val_t'(busy), val_t'(1));
    check_eq("req_ready_busy", val_t'(bus.req_ready), val_t'(0));
    k = 1;
    while (!bus.rsp_valid && k < LATENCY + 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("latency", val_t'(k), val_t'(LATENCY));
    check_eq("rsp_data", val_t'(bus.rsp_data), val_t'(ret));
    check_eq("frame_seen", val_t'(slv_frame), val_t'({mode, key, msg}));
    check_eq("tx_bits", val_t'(slv_tx_last), val_t'(FRAME_W));
    check_eq("rx_bits", val_t'(slv_rx_last), val_t'(BLK_W));
    check_eq("cs_n_at_rsp", val_t'(spi_cs_n), val_t'(1));
    held = bus.rsp_data;
    ok   = 1'b1;
    repeat (bp) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== held || bus.req_ready || !spi_cs_n) ok = 1'b0;
    end
    check_eq("backpressure_stable", val_t'(ok), val_t'(1));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", val_t'(bus.rsp_valid), val_t'(0));
    k = 0;
    while (!bus.req_ready && k < 50) begin
      k++;
      @(negedge clk);
    end
    check_eq("gap_cycles", val_t'(k), val_t'(CLK_DIV));
    prev_hold = hold;
  endtask

  task automatic abort_job(input bit in_recv, input int unsigned at_bit);
    int unsigned k;
    bus.req_mode  = 1'($urandom());
    bus.req_key   = rand_key();
    bus.req_msg   = rand_blk();
    bus.req_valid = 1'b1;
    slv_ret       = rand_blk() | {1'b1, {(BLK_W-1){1'b0}}};
    k = 0;
    while (!bus.req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    k = 0;
    while (((in_recv ? slv_rx : slv_tx) < at_bit) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_eq("abort_point_reached", val_t'((in_recv ? slv_rx : slv_tx) >= at_bit), val_t'(1));
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_cs_n", val_t'(spi_cs_n), val_t'(1));
    check_eq("abort_sclk", val_t'(spi_sclk), val_t'(0));
    check_eq("abort_mosi", val_t'(spi_mosi), val_t'(0));
    check_eq("abort_rsp_valid", val_t'(bus.rsp_valid), val_t'(0));
    check_eq("abort_busy", val_t'(busy), val_t'(0));
    check_eq("abort_req_ready", val_t'(bus.req_ready), val_t'(1));
    check_eq("abort_rsp_data", val_t'(bus.rsp_data), val_t'(0));
    rst = 1'b0;
    prev_hold = 1'b0;
  endtask

  initial begin
    logic [KEY_W-1:0] key;
    logic [BLK_W-1:0] pt;
    logic [BLK_W-1:0] ct;
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    pt  = 128'h00112233445566778899aabbccddeeff;
    ct  = 128'h8ea2b7ca516745bfeafc49904b496089;

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_mode  = 1'b0;
    bus.req_key   = '0;
    bus.req_msg   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_cs_n", val_t'(spi_cs_n), val_t'(1));
    check_eq("rst_sclk", val_t'(spi_sclk), val_t'(0));
    check_eq("rst_mosi", val_t'(spi_mosi), val_t'(0));
    check_eq("rst_req_ready", val_t'(bus.req_ready), val_t'(1));
    check_eq("rst_rsp_valid", val_t'(bus.rsp_valid), val_t'(0));
    check_eq("rst_busy", val_t'(busy), val_t'(0));
    check_eq("rst_rsp_data", val_t'(bus.rsp_data), val_t'(0));
    rst = 1'b0;
    @(negedge clk);

    run_job(MODE_ENC, key, pt, ct, 20, 1'b0);
    run_job(MODE_DEC, key, ct, pt, 0, 1'b0);

    abort_job(1'b0, 100);
    run_job(1'($urandom()), rand_key(), rand_blk(), rand_blk(), $urandom_range(0, 5), 1'b0);
    abort_job(1'b1, 50);
    run_job(1'($urandom()), rand_key(), rand_blk(), rand_blk(), $urandom_range(0, 5), 1'b0);

    run_job(1'($urandom()), rand_key(), rand_blk(), rand_blk(), 2, 1'b1);
    run_job(1'($urandom()), rand_key(), rand_blk(), rand_blk(), 3, 1'b0);

    for (int unsigned j = 0; j < 3; j++) begin
      run_job(1'($urandom()), rand_key(), rand_blk(), rand_blk(), $urandom_range(0, 5), 1'b0);
    end

    check_eq("idle_bus_quiet", val_t'(idle_viol), val_t'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
